// File: rtl/sram_block_controller.sv
// Block-to-byte SRAM initiator: moves one BLOCK_BYTES-byte block to or from a
// byte-wide asynchronous SRAM, one byte per ACCESS_CYCLES clocks, all pins registered.
module sram_block_controller #(
    parameter int ADDR_BITS     = 16,
    parameter int BLOCK_BYTES   = 16,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       req_read,
    input  logic                       req_write,
    input  logic [ADDR_BITS-1:0]       req_addr,
    input  logic [8*BLOCK_BYTES-1:0]   wdata_block,
    output logic [8*BLOCK_BYTES-1:0]   rdata_block,
    output logic                       busy,
    output logic                       done,
    output logic                       req_err,
    output logic                       sram_read_enable,
    output logic                       sram_write_enable,
    output logic [ADDR_BITS-1:0]       sram_address,
    output logic [7:0]                 sram_wdata,
    output logic                       sram_data_oe,
    input  logic [7:0]                 sram_rdata
);
    localparam int BLK_W = 8 * BLOCK_BYTES;
    localparam int IDX_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [BLK_W-1:0]     wblk_q, wblk_d;
    logic [BLK_W-1:0]     asm_q, asm_d;
    logic [BLK_W-1:0]     rdata_block_q, rdata_block_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 req_err_q, req_err_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 oe_q, oe_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;

    // Write data leaves MSB-first from a left-shifting copy of the block; read
    // bytes enter at the bottom so byte 0 ends up in the MSB slot after the last byte.
    always_comb begin
        state_d       = state_q;
        byte_idx_d    = byte_idx_q;
        wait_cnt_d    = wait_cnt_q;
        wblk_d        = wblk_q;
        asm_d         = asm_q;
        rdata_block_d = rdata_block_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        req_err_d     = 1'b0;
        rd_en_d       = rd_en_q;
        wr_en_d       = wr_en_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;

        case (state_q)
            ST_IDLE: begin
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
                if (req_read && req_write) begin
                    req_err_d = 1'b1;
                end else if (req_read || req_write) begin
                    state_d    = ST_ACCESS;
                    busy_d     = 1'b1;
                    rd_en_d    = req_read;
                    wr_en_d    = req_write;
                    addr_d     = req_addr;
                    wdata_d    = wdata_block[BLK_W-1 -: 8];
                    wblk_d     = wdata_block << 8;
                    byte_idx_d = '0;
                    wait_cnt_d = '0;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_q == LAST_CNT) begin
                    wait_cnt_d = '0;
                    if (rd_en_q) begin
                        asm_d = (asm_q << 8) | BLK_W'(sram_rdata);
                    end
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        rd_en_d = 1'b0;
                        wr_en_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        if (rd_en_q) begin
                            rdata_block_d = asm_d;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + IDX_ONE;
                        addr_d     = addr_q + ADDR_ONE;
                        wdata_d    = wblk_q[BLK_W-1 -: 8];
                        wblk_d     = wblk_q << 8;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                rd_en_d = 1'b0;
                wr_en_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        oe_d = wr_en_d;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            byte_idx_q    <= '0;
            wait_cnt_q    <= '0;
            wblk_q        <= '0;
            asm_q         <= '0;
            rdata_block_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            req_err_q     <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
            oe_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            byte_idx_q    <= byte_idx_d;
            wait_cnt_q    <= wait_cnt_d;
            wblk_q        <= wblk_d;
            asm_q         <= asm_d;
            rdata_block_q <= rdata_block_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            req_err_q     <= req_err_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
            oe_q          <= oe_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
        end
    end

    assign rdata_block       = rdata_block_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign req_err           = req_err_q;
    assign sram_read_enable  = rd_en_q;
    assign sram_write_enable = wr_en_q;
    assign sram_data_oe      = oe_q;
    assign sram_address      = addr_q;
    assign sram_wdata        = wdata_q;

endmodule

// File: tb/tb_sram_block_controller.sv
// Bench for sram_block_controller: SRAM emulation, a schedule-based reference
// model compared every cycle, and directed transfers with literal expectations.
module tb_sram_block_controller;
    localparam int AB    = 16;
    localparam int BB    = 16;
    localparam int AC    = 1;
    localparam int BLK_W = 8 * BB;
    localparam int TOTAL = BB * AC;

    logic             clk = 1'b0;
    logic             n_rst = 1'b1;
    logic             req_read = 1'b0;
    logic             req_write = 1'b0;
    logic [AB-1:0]    req_addr = '0;
    logic [BLK_W-1:0] wdata_block = '0;
    logic [BLK_W-1:0] rdata_block;
    logic             busy, done, req_err;
    logic             sram_read_enable, sram_write_enable, sram_data_oe;
    logic [AB-1:0]    sram_address;
    logic [7:0]       sram_wdata, sram_rdata;

    int checks = 0;
    int failures = 0;

    sram_block_controller #(.ADDR_BITS(AB), .BLOCK_BYTES(BB), .ACCESS_CYCLES(AC)) dut (
        .clk(clk), .n_rst(n_rst),
        .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
        .wdata_block(wdata_block), .rdata_block(rdata_block),
        .busy(busy), .done(done), .req_err(req_err),
        .sram_read_enable(sram_read_enable), .sram_write_enable(sram_write_enable),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_data_oe(sram_data_oe), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // Byte-wide SRAM seen through the pins
    logic [7:0] sram_mem [0:65535];
    assign sram_rdata = sram_read_enable ? sram_mem[sram_address] : 8'h00;
    always @(posedge clk) begin
        if (sram_write_enable) sram_mem[sram_address] = sram_wdata;
    end

    task automatic check(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of memory plus the timing schedule of one transfer
    logic [7:0]       ref_mem [0:65535];
    int               cyc, t_start, k, b;
    bit               have_xfer, idle_before, x_rd;
    logic [AB-1:0]    x_addr, a;
    logic [BLK_W-1:0] x_blk;
    logic             e_busy, e_rd, e_wr, e_done, e_err;
    logic [AB-1:0]    e_addr;
    logic [7:0]       e_wdata;
    logic [BLK_W-1:0] e_rdata;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cyc = 0; have_xfer = 0; t_start = 0;
            e_busy = 0; e_rd = 0; e_wr = 0; e_done = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
        end else begin
            cyc = cyc + 1;
            idle_before = !have_xfer || (cyc - 1 - t_start >= TOTAL + 1);
            e_err = 0;
            if (idle_before && req_read && req_write) begin
                e_err = 1;
            end else if (idle_before && (req_read != req_write)) begin
                have_xfer = 1; t_start = cyc; x_rd = req_read; x_addr = req_addr;
                for (int i = 0; i < BB; i++) begin
                    a = x_addr + 16'(i);
                    if (x_rd) begin
                        x_blk[BLK_W-1-8*i -: 8] = ref_mem[a];
                    end else begin
                        x_blk[BLK_W-1-8*i -: 8] = wdata_block[BLK_W-1-8*i -: 8];
                        ref_mem[a] = wdata_block[BLK_W-1-8*i -: 8];
                    end
                end
            end
            k = cyc - t_start;
            e_busy = 0; e_rd = 0; e_wr = 0; e_done = 0;
            if (have_xfer && k >= 0 && k < TOTAL) begin
                b = k / AC;
                e_busy = 1; e_rd = x_rd; e_wr = !x_rd;
                e_addr = x_addr + 16'(b);
                e_wdata = x_blk[BLK_W-1-8*b -: 8];
            end else if (have_xfer && k == TOTAL) begin
                e_done = 1;
                if (x_rd) e_rdata = x_blk;
            end
        end
    end

    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (n_rst) begin
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("req_err", req_err, e_err);
            check("read_enable", sram_read_enable, e_rd);
            check("write_enable", sram_write_enable, e_wr);
            check("data_oe", sram_data_oe, e_wr);
            if (e_rd || e_wr) check("address", sram_address, e_addr);
            if (e_wr) check("wdata", sram_wdata, e_wdata);
            check("rdata_block", rdata_block, e_rdata);
            check("rw_exclusive", sram_read_enable && sram_write_enable, 1'b0);
            if (prev_done) check("turnaround_gap", sram_read_enable || sram_write_enable, 1'b0);
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Leaves the caller in the first access cycle
    task automatic start_req(input logic rd, input logic wr, input logic [AB-1:0] addr, input logic [BLK_W-1:0] blk);
        tick();
        req_read = rd; req_write = wr; req_addr = addr; wdata_block = blk;
        tick();
        req_read = 1'b0; req_write = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            n = i;
            if (done) break;
        end
        if (!done) n = 101;
        $display("xfer done after %0d cycles rdata_block=%h", n, rdata_block);
    endtask

    localparam logic [BLK_W-1:0] BLK_A  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [BLK_W-1:0] BLK_B  = 128'hDEADBEEF0123456789ABCDEFFEDCBA98;
    localparam logic [BLK_W-1:0] BLK_FF = {BB{8'hFF}};

    int n, done_cnt;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            sram_mem[i] = 8'h00;
            ref_mem[i]  = 8'h00;
        end
        #1 n_rst = 1'b0;
        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_enables", {sram_read_enable, sram_write_enable, sram_data_oe}, 3'b000);
        check("rst_rdata", rdata_block, '0);
        @(posedge clk); #1 n_rst = 1'b1;

        // write block A at 0x0000
        start_req(1'b0, 1'b1, 16'h0000, BLK_A);
        check("wr_first_en", {sram_write_enable, sram_data_oe, sram_read_enable}, 3'b110);
        check("wr_first_addr", sram_address, 16'h0000);
        check("wr_first_data", sram_wdata, 8'h00);
        tick();
        check("wr_second_data", sram_wdata, 8'h11);
        check("wr_second_addr", sram_address, 16'h0001);
        wait_done(n);
        check("wr_latency", n, 15);

        // read it back
        start_req(1'b1, 1'b0, 16'h0000, '0);
        check("rd_first_en", {sram_read_enable, sram_write_enable, sram_data_oe}, 3'b100);
        wait_done(n);
        check("rd_latency", n, 16);
        check("rd_block_a", rdata_block, BLK_A);

        // write never disturbs rdata_block
        start_req(1'b0, 1'b1, 16'h0100, BLK_FF);
        wait_done(n);
        check("rdata_after_write", rdata_block, BLK_A);

        // wrapping write and read
        start_req(1'b0, 1'b1, 16'hFFF8, BLK_B);
        check("wrap_first_addr", sram_address, 16'hFFF8);
        repeat (8) tick();
        check("wrap_addr_0000", sram_address, 16'h0000);
        wait_done(n);
        check("wrap_wr_latency", n, 8);
        start_req(1'b1, 1'b0, 16'hFFF8, '0);
        wait_done(n);
        check("wrap_rd_block", rdata_block, BLK_B);

        // both requests together
        tick();
        req_read = 1'b1; req_write = 1'b1;
        tick();
        req_read = 1'b0; req_write = 1'b0;
        check("err_pulse", req_err, 1'b1);
        check("err_no_xfer", {busy, sram_read_enable, sram_write_enable}, 3'b000);
        tick();
        check("err_one_cycle", req_err, 1'b0);
        $display("xfer dual request rejected");

        // requests while busy and during DONE are ignored
        start_req(1'b1, 1'b0, 16'h0000, '0);
        repeat (3) tick();
        req_read = 1'b1;
        repeat (2) tick();
        req_read = 1'b0;
        wait_done(n);
        check("busy_req_latency", n, 11);
        req_read = 1'b1;
        tick();
        req_read = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("ignored_requests", done_cnt, 0);

        // reset during byte 5 of a read
        start_req(1'b1, 1'b0, 16'h0000, '0);
        repeat (5) tick();
        check("pre_rst_addr", sram_address, 16'h0005);
        #2 n_rst = 1'b0;
        #1;
        check("abort_enables", {sram_read_enable, sram_write_enable, sram_data_oe}, 3'b000);
        check("abort_busy", busy, 1'b0);
        check("abort_rdata", rdata_block, '0);
        tick();
        tick();
        check("abort_no_done", done, 1'b0);
        n_rst = 1'b1;
        $display("xfer aborted by reset");
        start_req(1'b1, 1'b0, 16'hFFF8, '0);
        wait_done(n);
        check("post_rst_latency", n, 16);
        check("post_rst_block", rdata_block, BLK_B);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_block_controller.md
Name: sram_block_controller

Overview:
- On-chip initiator for the off-chip byte-wide SRAM.
- Converts one 128-bit block request (read or write) from the AES datapath into sequential byte accesses on the SRAM read/write-enable, address and data interface.
- Presents the SRAM data bus as separate in, out and output-enable signals; the pad/top level owns the tristate buffer.

Parameters:
- ADDR_BITS, 16, SRAM address width.
- BLOCK_BYTES, 16, bytes per block transfer.
- ACCESS_CYCLES, 1, clock cycles per byte access (1 at a 12 ns clock covers 10 ns SRAM delay plus wire delay); must be ≥1.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset, asynchronous, active-low
- req_read  in  1  start block read (sampled in IDLE)
- req_write  in  1  start block write (sampled in IDLE)
- req_addr  in  ADDR_BITS  address of first byte
- wdata_block  in  8*BLOCK_BYTES  write data, byte 0 = MSB byte
- rdata_block  out  8*BLOCK_BYTES  last completed read block
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- req_err  out  1  one-cycle pulse: read and write requested together
- sram_read_enable  out  1  active-high SRAM read
- sram_write_enable  out  1  active-high SRAM write
- sram_address  out  ADDR_BITS  SRAM address
- sram_wdata  out  8  data driven to SRAM
- sram_data_oe  out  1  tristate enable for sram_wdata; always equals sram_write_enable
- sram_rdata  in  8  data from SRAM bus

Behaviour:
- Reset values (async, all outputs): every output 0; internal state IDLE; byte and wait counters 0.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Enables low.
  - Exactly one of req_read/req_write high: latch direction, req_addr and wdata_block; byte_idx=0; go to ACCESS next cycle; busy=1 from that cycle.
  - Both high: no transfer; req_err=1 for one cycle; stay in IDLE.
- ACCESS:
  - sram_address = latched addr + byte_idx, modulo 2^ADDR_BITS (wraps 0xFFFF→0x0000).
  - Exactly one enable high per direction; sram_data_oe = sram_write_enable.
  - Write: sram_wdata = byte byte_idx of latched block, i.e. bits [8*BLOCK_BYTES-1-8*byte_idx -: 8].
  - Each byte held for ACCESS_CYCLES cycles.
  - Read: on the last cycle of each access, sram_rdata is sampled into the byte byte_idx slot of an internal assembly register.
  - After the last cycle of byte BLOCK_BYTES-1, go to DONE; otherwise byte_idx+1.
- DONE (one cycle):
  - Enables low, busy=0, done=1.
  - For reads, rdata_block loads the assembly register this cycle.
  - Return to IDLE.
- rdata_block changes only on a read DONE; write transfers never alter it.
- Latency: request seen at clock edge N → first access cycle N+1 → done high in cycle N+1+BLOCK_BYTES*ACCESS_CYCLES (N+17 at defaults).
- Back-to-back: a request present during DONE is ignored; the earliest new start is the IDLE cycle after DONE. This guarantees at least one cycle with both enables low between transfers (bus turnaround).
- Requests while busy are ignored and raise no error.
- sram_read_enable and sram_write_enable are never high together, in any state.
- Reset mid-transfer: enables and sram_data_oe drop asynchronously; the transfer is aborted; rdata_block is cleared; no done pulse.
- All outputs are registered (no combinational path from request inputs to SRAM pins).

Test Plan:
- Write req_addr=0x0000, wdata_block=0x00112233445566778899AABBCCDDEEFF → sram_write_enable high cycles N+1..N+16, address 0x0000..0x000F, sram_wdata 0x00..0xFF, sram_data_oe tracks write_enable, done at N+17.
- Read back 0x0000 from the SRAM model → sram_read_enable high 16 cycles, rdata_block=0x00112233...EEFF at done, unchanged by a subsequent write of all 0xFF bytes.
- req_addr=0xFFF8 write then read → addresses 0xFFF8..0xFFFF then 0x0000..0x0007; read returns the identical block.
- req_read=req_write=1 in IDLE → req_err pulse 1 cycle, no enable asserted, busy stays 0; new req_read during busy → ignored, only one done pulse.
- n_rst low during byte 5 of a read → enables/oe/busy 0 immediately, rdata_block=0, no done; a fresh read after reset completes normally.
- Every cycle of all runs: assert never (sram_read_enable && sram_write_enable); assert at least 1 idle cycle between consecutive transfers.
